// File: rtl/calc_pkg.sv
// Shared types for the sequential BCD calculator: op encodings, FSM states, digit type.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL_SHIFT,
    MUL_ADD,
    DIV_SHIFT,
    DIV_SUB,
    DONE
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // Limits a repeat count to 9 so non-BCD digits cannot stretch an iteration.
  function automatic bcd_digit_t clamp9(input bcd_digit_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_addsub.sv
// Combinational ripple BCD adder/subtractor; cout is decimal carry (add) or borrow (sub).
module bcd_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                sub,
  output logic [4*DIGITS-1:0] y,
  output logic                cout
);

  always_comb begin
    logic       c;
    logic [4:0] t;
    c = 1'b0;
    t = '0;
    y = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sub) begin
        t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, c};
        c = t[4];
        if (c) t = t + 5'd10;
      end else begin
        t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
        c = (t > 5'd9);
        if (c) t = t + 5'd6;
      end
      y[4*i +: 4] = t[3:0];
    end
    cout = c;
  end

endmodule

// File: rtl/bcd_calc_seq.sv
// Multi-cycle BCD calculator: single-cycle add/sub, digit-serial multiply and divide.
// Define BCD_CHECK_EN to reject operands containing nibbles above 9.
module bcd_calc_seq
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          switches,
  input  logic [4*DIGITS-1:0] operand1,
  input  logic [4*DIGITS-1:0] operand2,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic [4*DIGITS-1:0] mod,
  output logic                negative,
  output logic                overflow,
  output logic                error
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(DIGITS - 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [W-1:0]  result_q, result_d, mod_q, mod_d;
  logic [W+3:0]  rem_q, rem_d;
  logic [IW-1:0] idx_q, idx_d;
  bcd_digit_t    cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;

  logic [W+3:0]  as_a, as_b, as_y;
  logic          as_sub, as_cout;
  bcd_digit_t    a_digit, b_digit;
  logic          bad_bcd;

  // One extra digit so divide's shifted remainder and add's carry digit both fit.
  bcd_addsub #(.DIGITS(DIGITS + 1)) u_addsub (
    .a    (as_a),
    .b    (as_b),
    .sub  (as_sub),
    .y    (as_y),
    .cout (as_cout)
  );

  assign a_digit = a_q[4*idx_q +: 4];
  assign b_digit = b_q[4*idx_q +: 4];

`ifdef BCD_CHECK_EN
  function automatic logic has_bad_digit(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (x[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction
  assign bad_bcd = has_bad_digit(a_q) || has_bad_digit(b_q);
`else
  assign bad_bcd = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    mod_d    = mod_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    as_a     = '0;
    as_b     = '0;
    as_sub   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op_e'(switches);
          a_d      = operand1;
          b_d      = operand2;
          result_d = '0;
          mod_d    = '0;
          neg_d    = 1'b0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        if (bad_bcd) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          case (op_q)
            OP_ADD: begin
              as_a     = {4'h0, a_q};
              as_b     = {4'h0, b_q};
              result_d = as_y[W-1:0];
              ovf_d    = |as_y[W +: 4];
              state_d  = DONE;
            end
            OP_SUB: begin
              // Packed BCD orders the same as binary, so a plain compare picks the minuend.
              as_sub = 1'b1;
              if (a_q < b_q) begin
                as_a  = {4'h0, b_q};
                as_b  = {4'h0, a_q};
                neg_d = 1'b1;
              end else begin
                as_a  = {4'h0, a_q};
                as_b  = {4'h0, b_q};
              end
              result_d = as_y[W-1:0];
              state_d  = DONE;
            end
            OP_MUL: begin
              idx_d   = IDX_TOP;
              state_d = MUL_SHIFT;
            end
            default: begin
              if (b_q == '0) begin
                err_d   = 1'b1;
                state_d = DONE;
              end else begin
                idx_d   = IDX_TOP;
                rem_d   = '0;
                state_d = DIV_SHIFT;
              end
            end
          endcase
        end
      end

      MUL_SHIFT: begin
        ovf_d    = ovf_q | (|result_q[W-1 -: 4]);
        result_d = {result_q[W-5:0], 4'h0};
        cnt_d    = clamp9(b_digit);
        if (clamp9(b_digit) != 4'd0) begin
          state_d = MUL_ADD;
        end else if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end

      MUL_ADD: begin
        as_a     = {4'h0, result_q};
        as_b     = {4'h0, a_q};
        result_d = as_y[W-1:0];
        ovf_d    = ovf_q | (|as_y[W +: 4]);
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = MUL_SHIFT;
          end
        end
      end

      DIV_SHIFT: begin
        rem_d    = {rem_q[W-1:0], a_digit};
        result_d = {result_q[W-5:0], 4'h0};
        state_d  = DIV_SUB;
      end

      DIV_SUB: begin
        as_a   = rem_q;
        as_b   = {4'h0, b_q};
        as_sub = 1'b1;
        // Capping the quotient digit at 9 bounds the loop even for non-BCD operands.
        if (!as_cout && (result_q[3:0] != 4'd9)) begin
          rem_d    = as_y;
          result_d = {result_q[W-1:4], result_q[3:0] + 4'd1};
        end else if (idx_q == '0) begin
          mod_d   = rem_q[W-1:0];
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = DIV_SHIFT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mod_q    <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      mod_q    <= mod_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign mod      = mod_q;
  assign negative = neg_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_bcd_calc_seq.sv
// Self-checking bench for bcd_calc_seq: directed table, hand sequences, random vs integer model.
module tb_bcd_calc_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
  localparam int          POW    = 10 ** DIGITS;
  localparam int          BUDGET = 80;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [1:0]    switches;
  logic [W-1:0]  operand1, operand2;
  logic          busy, done, negative, overflow, error;
  logic [W-1:0]  result, mod;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_calc_seq #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .switches (switches),
    .operand1 (operand1),
    .operand2 (operand2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .mod      (mod),
    .negative (negative),
    .overflow (overflow),
    .error    (error)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] md;
    logic         neg;
    logic         ovf;
    logic         err;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int b2i(input logic [W-1:0] x);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] i2b(input int v);
    logic [W-1:0] y;
    int n;
    n = v;
    y = '0;
    for (int i = 0; i < DIGITS; i++) begin
      y[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return y;
  endfunction

  function automatic int digsum(input int v);
    int s, n;
    s = 0;
    n = v;
    while (n > 0) begin
      s += n % 10;
      n /= 10;
    end
    return s;
  endfunction

  // Reference: decode to integers, do the arithmetic, re-encode; latency from the digit sums.
  function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    int x, y, r;
    x = b2i(a);
    y = b2i(b);
    v.op = op; v.a = a; v.b = b;
    v.res = '0; v.md = '0; v.neg = 1'b0; v.ovf = 1'b0; v.err = 1'b0; v.lat = 1;
    case (op)
      2'b00: begin
        r = x + y;
        v.res = i2b(r % POW);
        v.ovf = (r >= POW);
      end
      2'b01: begin
        if (x >= y) v.res = i2b(x - y);
        else begin
          v.res = i2b(y - x);
          v.neg = 1'b1;
        end
      end
      2'b10: begin
        r = x * y;
        v.res = i2b(r % POW);
        v.ovf = (r >= POW);
        v.lat = DIGITS + digsum(y) + 1;
      end
      default: begin
        if (y == 0) v.err = 1'b1;
        else begin
          v.res = i2b(x / y);
          v.md  = i2b(x % y);
          v.lat = 2 * DIGITS + digsum(x / y) + 1;
        end
      end
    endcase
    return v;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    switches = op;
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    issue(v.op, v.a, v.b);
    wait_done(lat);
    check({tag, ".latency"},  lat,      v.lat);
    check({tag, ".result"},   result,   v.res);
    check({tag, ".mod"},      mod,      v.md);
    check({tag, ".negative"}, negative, v.neg);
    check({tag, ".overflow"}, overflow, v.ovf);
    check({tag, ".error"},    error,    v.err);
    check({tag, ".busy_at_done"}, busy, 1'b0);
    @(posedge clk);
    #1;
    check({tag, ".done_pulse"}, done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    vec_t v;
    int   lat;
    int   seen;
    logic [W-1:0] ra, rb;

    vecs[0] = '{2'b00, 16'h1949, 16'h2818, 16'h4767, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{2'b00, 16'h9889, 16'h8997, 16'h8886, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[2] = '{2'b01, 16'h9123, 16'h8456, 16'h0667, 16'h0000, 1'b0, 1'b0, 1'b0, 1};
    vecs[3] = '{2'b01, 16'h1237, 16'h2130, 16'h0893, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    vecs[4] = '{2'b10, 16'h0137, 16'h0053, 16'h7261, 16'h0000, 1'b0, 1'b0, 1'b0, 13};
    vecs[5] = '{2'b10, 16'h0137, 16'h2553, 16'h9761, 16'h0000, 1'b0, 1'b1, 1'b0, 20};
    vecs[6] = '{2'b11, 16'h2556, 16'h0023, 16'h0111, 16'h0003, 1'b0, 1'b0, 1'b0, 12};
    vecs[7] = '{2'b11, 16'h2367, 16'h3475, 16'h0000, 16'h2367, 1'b0, 1'b0, 1'b0, 9};
    vecs[8] = '{2'b11, 16'h1425, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1};

    rst = 1'b1; start = 1'b0; switches = '0; operand1 = '0; operand2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.result", result, '0);
    check("reset.mod", mod, '0);
    check("reset.flags", {busy, done, negative, overflow, error}, 5'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start pulsed while a multiply is in flight must be dropped.
    issue(2'b10, 16'h0137, 16'h0053);
    lat = -1;
    for (int k = 1; k <= BUDGET; k++) begin
      if (k == 3) begin
        @(negedge clk);
        switches = 2'b00; operand1 = 16'h1111; operand2 = 16'h1111; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (k == 2) check("busy_start.busy_mid", busy, 1'b1);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("busy_start.latency", lat, 13);
    check("busy_start.result", result, 16'h7261);
    check("busy_start.overflow", overflow, 1'b0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("busy_start.no_extra_done", seen, 0);
    check("busy_start.result_held", result, 16'h7261);

    // Reset in the middle of a divide aborts without a done pulse.
    issue(2'b11, 16'h2556, 16'h0023);
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid.busy_before", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid.result", result, '0);
    check("rst_mid.mod", mod, '0);
    check("rst_mid.flags", {busy, done, negative, overflow, error}, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    check("rst_mid.no_done", seen, 0);

    // Non-BCD operands.
    issue(2'b00, 16'h00A1, 16'h0001);
    wait_done(lat);
`ifdef BCD_CHECK_EN
    check("badbcd.latency", lat, 1);
    check("badbcd.error", error, 1'b1);
    check("badbcd.result", result, '0);
    check("badbcd.mod", mod, '0);
    check("badbcd.flags", {negative, overflow}, 2'b0);
`else
    check("badbcd_add.bounded", (lat >= 1) && (lat <= 10 * DIGITS + 1), 1'b1);
`endif
    @(posedge clk);
    #1;
    issue(2'b10, 16'h0012, 16'hFFFF);
    wait_done(lat);
`ifdef BCD_CHECK_EN
    check("badbcd_mul.latency", lat, 1);
    check("badbcd_mul.error", error, 1'b1);
`else
    check("badbcd_mul.bounded", (lat >= 1) && (lat <= 10 * DIGITS + 1), 1'b1);
`endif
    @(posedge clk);
    #1;
    issue(2'b11, 16'hFFFF, 16'h0001);
    wait_done(lat);
`ifdef BCD_CHECK_EN
    check("badbcd_div.latency", lat, 1);
    check("badbcd_div.error", error, 1'b1);
`else
    check("badbcd_div.bounded", (lat >= 1) && (lat <= 11 * DIGITS + 1), 1'b1);
`endif
    @(posedge clk);
    #1;

    // Random BCD operands against the integer reference.
    for (int n = 0; n < 150; n++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      rb = rb >> (4 * $urandom_range(0, DIGITS - 1));
      if ($urandom_range(0, 15) == 0) rb = '0;
      v = model(2'($urandom_range(0, 3)), ra, rb);
      run_vec(v, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_calc_seq.md
# bcd_calc_seq

Parametrised, multi-cycle BCD calculator core. It is the sequential successor to the combinational calculate unit. It accepts two DIGITS-digit packed-BCD operands and a 2-bit operation select under a start/done handshake. Add and subtract complete in one cycle; multiply and divide iterate digit-serially. It sits between the operand-entry/keypad logic and the display driver, and reports result, remainder, sign, overflow and error flags.

## Interface
- DIGITS, 4: number of BCD digits per operand/result; data width W = 4*DIGITS
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- switches  in  2  op select: 00 add, 01 subtract, 10 multiply, 11 divide
- operand1  in  W  BCD operand A / dividend; latched on accepted start
- operand2  in  W  BCD operand B / divisor; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse, result flags valid
- result  out  W  BCD result (low DIGITS digits of the true result)
- mod  out  W  BCD remainder (divide only, else 0)
- negative  out  1  subtract with operand1 < operand2
- overflow  out  1  true result needs more than DIGITS digits
- error  out  1  divide by zero (and invalid BCD, see Configuration)

## Operation
- Reset: state IDLE; busy, done, negative, overflow, error = 0; result, mod = 0.
- IDLE: start=1 latches switches/operands, clears flags, sets busy. Start while busy is ignored.
- Outputs hold their values from done until the next accepted start.
- Add: result = A+B mod 10^DIGITS; overflow = decimal carry out.
- Subtract: if A>=B, result = A-B; else result = B-A and negative=1. Never overflows.
- Multiply, states MUL_SHIFT/MUL_ADD, scanning B digits MSD→LSD:
  - MUL_SHIFT: acc = acc×10 (one-digit left shift); load counter = current B digit.
  - MUL_ADD: acc += A once per cycle until the counter reaches 0. A zero digit skips MUL_ADD.
  - overflow is sticky: set if a nonzero digit is shifted out or any add carries out.
- Divide, states DIV_SHIFT/DIV_SUB, restoring decimal long division over A digits MSD→LSD:
  - DIV_SHIFT: rem = rem×10 + next A digit.
  - DIV_SUB: each cycle, if rem>=B then rem -= B and quotient digit++; otherwise advance to the next digit (that cycle is consumed).
  - End: result = quotient, mod = rem.
- Divide with B=0: no iteration; error=1, result=0, mod=0.
- DONE: drives done=1 for one cycle, clears busy, returns to IDLE.
- rst mid-operation aborts immediately; no done is produced.

## Timing
- Latency is counted from the start-sampling edge to the edge at which done is high.
- Add, subtract, divide-by-zero, invalid-BCD error: 1 cycle.
- Multiply: DIGITS + Σ(B digits) + 1 cycles; maximum 10·DIGITS + 1.
- Divide: 2·DIGITS + Σ(quotient digits) + 1 cycles; maximum 11·DIGITS + 1.
- The earliest next start is accepted in the cycle after done (back-to-back).
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- BCD_CHECK_EN defined: on start, any operand nibble > 9 gives error=1, result=mod=0, overflow=negative=0, with 1-cycle latency, for every op.
- BCD_CHECK_EN undefined: no digit validation. error reflects divide-by-zero only. Results for non-BCD inputs are unspecified but the FSM still terminates within the maximum latency.

## Structure
- calc_pkg:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - FSM state enum (IDLE, EXEC, MUL_SHIFT, MUL_ADD, DIV_SHIFT, DIV_SUB, DONE)
  - bcd_digit_t (4-bit)
- Sub-module bcd_addsub: combinational DIGITS-digit BCD adder/subtractor with carry/borrow out. It is shared by add, subtract, multiply accumulate and divide compare/subtract; the compare uses its borrow.

## Test plan
- add 0x1949+0x2818 -> result 0x4767, overflow 0, latency 1; add 0x9889+0x8997 -> result 0x8886, overflow 1.
- sub 0x9123−0x8456 -> result 0x0667, negative 0; sub 0x1237−0x2130 -> result 0x0893, negative 1.
- mul 0x0137×0x0053 -> result 0x7261, overflow 0, latency 13; mul 0x0137×0x2553 -> result 0x9761, overflow 1.
- div 0x2556÷0x0023 -> result 0x0111, mod 0x0003; div 0x2367÷0x3475 -> result 0, mod 0x2367; div 0x1425÷0 -> error 1, latency 1.
- start pulsed while busy during a multiply -> ignored, original result intact; rst asserted mid-divide -> all outputs 0 next cycle, no done.
- With BCD_CHECK_EN, add 0x00A1+0x0001 -> error 1, result 0. Without it, the FSM reaches done within the maximum latency.
